// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared states, defaults and geometry helpers for the direct-mapped cache
package cache_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WB,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_BYPASS
  } state_e;

  localparam int SIZE_DEF       = 8192;
  localparam int LINE_WORDS_DEF = 8;

  // Word-offset bits within a line.
  function automatic int off_width(input int line_words);
    return $clog2(line_words);
  endfunction

  // Line-index bits: one index per line of LINE_WORDS 32-bit words.
  function automatic int idx_width(input int size, input int line_words);
    return $clog2(size / (4 * line_words));
  endfunction

  // Tag bits: everything above the index, byte lanes excluded.
  function automatic int tag_width(input int size, input int line_words);
    return 30 - off_width(line_words) - idx_width(size, line_words);
  endfunction

endpackage

// File: rtl/cache_line_mem.sv
// rtl/cache_line_mem.sv - valid/dirty/tag/data arrays with combinational lookup and byte-lane writes
module cache_line_mem #(
  parameter int OW = 3,
  parameter int IW = 8,
  parameter int TW = 19
) (
  input  logic          clk,
  input  logic [IW-1:0] lk_index_i,
  input  logic [OW-1:0] lk_offset_i,
  output logic          lk_valid_o,
  output logic          lk_dirty_o,
  output logic [TW-1:0] lk_tag_o,
  output logic [31:0]   lk_word_o,
  input  logic          dw_en_i,
  input  logic [IW-1:0] dw_index_i,
  input  logic [OW-1:0] dw_offset_i,
  input  logic [3:0]    dw_be_i,
  input  logic [31:0]   dw_data_i,
  input  logic          mw_en_i,
  input  logic [IW-1:0] mw_index_i,
  input  logic          mw_valid_i,
  input  logic          mw_dirty_i,
  input  logic [TW-1:0] mw_tag_i
);

  localparam int LINES = 1 << IW;
  localparam int LW    = 1 << OW;

  logic          valid_q [LINES];
  logic          dirty_q [LINES];
  logic [TW-1:0] tag_q   [LINES];
  logic [31:0]   data_q  [LINES][LW];

  assign lk_valid_o = valid_q[lk_index_i];
  assign lk_dirty_o = dirty_q[lk_index_i];
  assign lk_tag_o   = tag_q[lk_index_i];
  assign lk_word_o  = data_q[lk_index_i][lk_offset_i];

  // Metadata update: invalidation sweep, fill completion and dirty marking share one port.
  always_ff @(posedge clk) begin
    if (mw_en_i) begin
      valid_q[mw_index_i] <= mw_valid_i;
      dirty_q[mw_index_i] <= mw_dirty_i;
      tag_q[mw_index_i]   <= mw_tag_i;
    end
  end

  // Data word write, only the enabled byte lanes change.
  always_ff @(posedge clk) begin
    if (dw_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (dw_be_i[b]) begin
          data_q[dw_index_i][dw_offset_i][8*b +: 8] <= dw_data_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/cache.sv
// rtl/cache.sv - direct-mapped write-back cache, s0 cached, s1 uncached pass-through (CACHE_S1_BYPASS_EN)
module cache
  import cache_pkg::*;
#(
  parameter int SIZE       = SIZE_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] s0_address,
  input  logic [3:0]  s0_byteEnable,
  input  logic        s0_read,
  output logic [31:0] s0_readData,
  input  logic        s0_write,
  input  logic [31:0] s0_writeData,
  output logic        s0_waitRequest,
  output logic        s0_readDataValid,
  input  logic [31:0] s1_address,
  input  logic [3:0]  s1_byteEnable,
  input  logic        s1_read,
  output logic [31:0] s1_readData,
  input  logic        s1_write,
  input  logic [31:0] s1_writeData,
  output logic        s1_waitRequest,
  output logic        s1_readDataValid,
  output logic [31:0] m0_address,
  output logic [3:0]  m0_byteEnable,
  output logic        m0_read,
  input  logic [31:0] m0_readData,
  output logic        m0_write,
  output logic [31:0] m0_writeData,
  input  logic        m0_waitRequest,
  input  logic        m0_readDataValid,
  output logic        m0_beginBurstTransfer,
  output logic [7:0]  m0_burstCount
);

  localparam int OW = off_width(LINE_WORDS);
  localparam int IW = idx_width(SIZE, LINE_WORDS);
  localparam int TW = tag_width(SIZE, LINE_WORDS);

  state_e        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [OW-1:0] beat_q, beat_d;
  logic [OW-1:0] rcnt_q, rcnt_d;
  logic [31:0]   s0_rdata_q, s0_rdata_d;
  logic          s0_rvalid_q, s0_rvalid_d;

  logic [TW-1:0] s0_tag;
  logic [IW-1:0] s0_idx;
  logic [OW-1:0] s0_off;
  logic          s0_req;
  logic          hit;

  logic [OW-1:0] lk_off;
  logic          lk_valid, lk_dirty;
  logic [TW-1:0] lk_tag;
  logic [31:0]   lk_word;
  logic          dw_en;
  logic [OW-1:0] dw_off;
  logic [3:0]    dw_be;
  logic [31:0]   dw_data;
  logic          mw_en;
  logic [IW-1:0] mw_index;
  logic          mw_valid, mw_dirty;
  logic [TW-1:0] mw_tag;

`ifdef CACHE_S1_BYPASS_EN
  logic          byp_wait_q, byp_wait_d;
  logic [31:0]   s1_rdata_q, s1_rdata_d;
  logic          s1_rvalid_q, s1_rvalid_d;
  logic          s1_wait;
  logic          unused_addr;
  assign unused_addr = ^{s0_address[1:0], s1_address[1:0]};
`else
  logic          unused_s1;
  assign unused_s1 = ^{s0_address[1:0], s1_address, s1_byteEnable, s1_read,
                       s1_write, s1_writeData};
`endif

  assign s0_tag = s0_address[31 -: TW];
  assign s0_idx = s0_address[OW+2 +: IW];
  assign s0_off = s0_address[2 +: OW];
  assign s0_req = s0_read | s0_write;
  assign hit    = lk_valid && (lk_tag == s0_tag);

  // Every lookup and refill targets the line selected by the pending s0 address.
  cache_line_mem #(.OW(OW), .IW(IW), .TW(TW)) u_mem (
    .clk         (clk),
    .lk_index_i  (s0_idx),
    .lk_offset_i (lk_off),
    .lk_valid_o  (lk_valid),
    .lk_dirty_o  (lk_dirty),
    .lk_tag_o    (lk_tag),
    .lk_word_o   (lk_word),
    .dw_en_i     (dw_en),
    .dw_index_i  (s0_idx),
    .dw_offset_i (dw_off),
    .dw_be_i     (dw_be),
    .dw_data_i   (dw_data),
    .mw_en_i     (mw_en),
    .mw_index_i  (mw_index),
    .mw_valid_i  (mw_valid),
    .mw_dirty_i  (mw_dirty),
    .mw_tag_i    (mw_tag)
  );

  // Next-state, array control and port outputs.
  always_comb begin
    state_d               = state_q;
    init_cnt_d            = init_cnt_q;
    beat_d                = beat_q;
    rcnt_d                = rcnt_q;
    s0_rdata_d            = s0_rdata_q;
    s0_rvalid_d           = 1'b0;
    s0_waitRequest        = 1'b1;
    m0_address            = '0;
    m0_byteEnable         = '0;
    m0_read               = 1'b0;
    m0_write              = 1'b0;
    m0_writeData          = '0;
    m0_beginBurstTransfer = 1'b0;
    m0_burstCount         = '0;
    lk_off                = s0_off;
    dw_en                 = 1'b0;
    dw_off                = s0_off;
    dw_be                 = '0;
    dw_data               = '0;
    mw_en                 = 1'b0;
    mw_index              = s0_idx;
    mw_valid              = 1'b0;
    mw_dirty              = 1'b0;
    mw_tag                = s0_tag;
`ifdef CACHE_S1_BYPASS_EN
    byp_wait_d            = byp_wait_q;
    s1_rdata_d            = s1_rdata_q;
    s1_rvalid_d           = 1'b0;
    s1_wait               = 1'b1;
`endif
    case (state_q)
      ST_INIT: begin
        mw_en      = 1'b1;
        mw_index   = init_cnt_q;
        mw_tag     = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        s0_waitRequest = 1'b0;
        if (s0_req) begin
          if (hit) begin
            if (s0_write) begin
              dw_en    = 1'b1;
              dw_be    = s0_byteEnable;
              dw_data  = s0_writeData;
              mw_en    = 1'b1;
              mw_valid = 1'b1;
              mw_dirty = 1'b1;
            end else begin
              s0_rdata_d  = lk_word;
              s0_rvalid_d = 1'b1;
            end
          end else begin
            s0_waitRequest = 1'b1;
            beat_d         = '0;
            rcnt_d         = '0;
            state_d        = (lk_valid && lk_dirty) ? ST_WB : ST_FILL_REQ;
          end
        end
`ifdef CACHE_S1_BYPASS_EN
        else if (s1_read || s1_write) begin
          byp_wait_d = 1'b0;
          state_d    = ST_BYPASS;
        end
`endif
      end
      ST_WB: begin
        lk_off                = beat_q;
        m0_write              = 1'b1;
        m0_byteEnable         = 4'hF;
        m0_writeData          = lk_word;
        m0_address            = {lk_tag, s0_idx, beat_q, 2'b00};
        m0_burstCount         = 8'(LINE_WORDS);
        m0_beginBurstTransfer = (beat_q == '0);
        if (!m0_waitRequest) begin
          beat_d = beat_q + 1'b1;
          if (&beat_q) state_d = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: begin
        m0_read               = 1'b1;
        m0_byteEnable         = 4'hF;
        m0_address            = {s0_tag, s0_idx, beat_q, 2'b00};
        m0_burstCount         = 8'(LINE_WORDS);
        m0_beginBurstTransfer = (beat_q == '0);
        if (!m0_waitRequest) begin
          beat_d = beat_q + 1'b1;
          if (&beat_q) state_d = ST_FILL_WAIT;
        end
      end
      ST_FILL_WAIT: begin
      end
`ifdef CACHE_S1_BYPASS_EN
      ST_BYPASS: begin
        if (!byp_wait_q) begin
          m0_read       = s1_read && !s1_write;
          m0_write      = s1_write;
          m0_address    = {s1_address[31:2], 2'b00};
          m0_byteEnable = s1_byteEnable;
          m0_writeData  = s1_writeData;
          m0_burstCount = 8'd1;
          if (!m0_waitRequest) begin
            s1_wait = 1'b0;
            if (s1_write) state_d = ST_IDLE;
            else          byp_wait_d = 1'b1;
          end
        end else if (m0_readDataValid) begin
          s1_rdata_d  = m0_readData;
          s1_rvalid_d = 1'b1;
          byp_wait_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Refill words can return while later read beats are still being issued.
    if ((state_q == ST_FILL_REQ || state_q == ST_FILL_WAIT) && m0_readDataValid) begin
      dw_en   = 1'b1;
      dw_off  = rcnt_q;
      dw_be   = 4'hF;
      dw_data = m0_readData;
      rcnt_d  = rcnt_q + 1'b1;
      if (state_q == ST_FILL_WAIT && (&rcnt_q)) begin
        mw_en    = 1'b1;
        mw_valid = 1'b1;
        mw_dirty = 1'b0;
        state_d  = ST_IDLE;
      end
    end
  end

  // State and response registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      beat_q      <= '0;
      rcnt_q      <= '0;
      s0_rdata_q  <= '0;
      s0_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      beat_q      <= beat_d;
      rcnt_q      <= rcnt_d;
      s0_rdata_q  <= s0_rdata_d;
      s0_rvalid_q <= s0_rvalid_d;
    end
  end

  assign s0_readData      = s0_rdata_q;
  assign s0_readDataValid = s0_rvalid_q;

`ifdef CACHE_S1_BYPASS_EN
  // Uncached-port response registers.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      byp_wait_q  <= 1'b0;
      s1_rdata_q  <= '0;
      s1_rvalid_q <= 1'b0;
    end else begin
      byp_wait_q  <= byp_wait_d;
      s1_rdata_q  <= s1_rdata_d;
      s1_rvalid_q <= s1_rvalid_d;
    end
  end

  assign s1_waitRequest   = s1_wait;
  assign s1_readData      = s1_rdata_q;
  assign s1_readDataValid = s1_rvalid_q;
`else
  assign s1_waitRequest   = 1'b1;
  assign s1_readData      = '0;
  assign s1_readDataValid = 1'b0;
`endif

endmodule

// File: tb/tb_cache.sv
// tb/tb_cache.sv - directed and randomized self-checking bench for cache
module tb_cache;

  localparam int LIM = 3000;

  logic        clk = 1'b0;
  logic        rest;
  logic [31:0] s0_address, s0_readData, s0_writeData;
  logic [3:0]  s0_byteEnable;
  logic        s0_read, s0_write, s0_waitRequest, s0_readDataValid;
  logic [31:0] s1_address, s1_readData, s1_writeData;
  logic [3:0]  s1_byteEnable;
  logic        s1_read, s1_write, s1_waitRequest, s1_readDataValid;
  logic [31:0] m0_address, m0_readData, m0_writeData;
  logic [3:0]  m0_byteEnable;
  logic        m0_read, m0_write, m0_waitRequest, m0_readDataValid;
  logic        m0_beginBurstTransfer;
  logic [7:0]  m0_burstCount;

  int checks = 0;
  int errors = 0;

  logic        rand_wait = 1'b0;
  int          cyc = 0;
  logic [31:0] mem    [int unsigned];
  logic [31:0] shadow [int unsigned];
  logic [31:0] rq_addr[$];
  int          rq_cyc[$];
  logic [31:0] lg_addr[$];
  logic [31:0] lg_data[$];
  logic        lg_wr[$];
  logic        lg_bg[$];
  logic [7:0]  lg_bc[$];

  cache dut (
    .clk(clk), .rest(rest),
    .s0_address(s0_address), .s0_byteEnable(s0_byteEnable), .s0_read(s0_read),
    .s0_readData(s0_readData), .s0_write(s0_write), .s0_writeData(s0_writeData),
    .s0_waitRequest(s0_waitRequest), .s0_readDataValid(s0_readDataValid),
    .s1_address(s1_address), .s1_byteEnable(s1_byteEnable), .s1_read(s1_read),
    .s1_readData(s1_readData), .s1_write(s1_write), .s1_writeData(s1_writeData),
    .s1_waitRequest(s1_waitRequest), .s1_readDataValid(s1_readDataValid),
    .m0_address(m0_address), .m0_byteEnable(m0_byteEnable), .m0_read(m0_read),
    .m0_readData(m0_readData), .m0_write(m0_write), .m0_writeData(m0_writeData),
    .m0_waitRequest(m0_waitRequest), .m0_readDataValid(m0_readDataValid),
    .m0_beginBurstTransfer(m0_beginBurstTransfer), .m0_burstCount(m0_burstCount)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] sh_rd(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return mem_rd(a);
  endfunction

  task automatic clr_log();
    lg_addr.delete(); lg_data.delete(); lg_wr.delete(); lg_bg.delete(); lg_bc.delete();
  endtask

  // Memory model on m0: random stalls, variable read latency, beat log and hold checks.
  initial begin
    logic        held;
    logic [31:0] h_addr, h_data;
    logic [31:0] h_ctl;
    held = 1'b0; h_addr = '0; h_data = '0; h_ctl = '0;
    m0_waitRequest = 1'b0; m0_readDataValid = 1'b0; m0_readData = '0;
    forever begin
      @(negedge clk);
      cyc++;
      m0_readDataValid = 1'b0;
      if (rq_addr.size() > 0 && rq_cyc[0] < cyc && !(rand_wait && $urandom_range(0, 1) == 1)) begin
        m0_readDataValid = 1'b1;
        m0_readData      = mem_rd(rq_addr[0]);
        void'(rq_addr.pop_front());
        void'(rq_cyc.pop_front());
      end
      m0_waitRequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (held) begin
        chk("hold_addr", m0_address, h_addr);
        chk("hold_data", m0_writeData, h_data);
        chk("hold_ctl", {17'h0, m0_read, m0_write, m0_byteEnable, m0_beginBurstTransfer,
                         m0_burstCount}, h_ctl);
      end
      held = 1'b0;
      if (m0_read || m0_write) begin
        if (m0_waitRequest) begin
          held   = 1'b1;
          h_addr = m0_address;
          h_data = m0_writeData;
          h_ctl  = {17'h0, m0_read, m0_write, m0_byteEnable, m0_beginBurstTransfer, m0_burstCount};
        end else begin
          lg_addr.push_back(m0_address);
          lg_data.push_back(m0_writeData);
          lg_wr.push_back(m0_write);
          lg_bg.push_back(m0_beginBurstTransfer);
          lg_bc.push_back(m0_burstCount);
          if (m0_write) mem[m0_address] = merge(mem_rd(m0_address), m0_writeData, m0_byteEnable);
          else begin
            rq_addr.push_back(m0_address);
            rq_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic s0_rd(input logic [31:0] a, output logic [31:0] d, output int w);
    @(negedge clk);
    s0_address = a; s0_read = 1'b1; s0_write = 1'b0; w = 0;
    #1;
    while (s0_waitRequest !== 1'b0 && w < LIM) begin @(negedge clk); #1; w++; end
    chk("s0_rd_accept", 32'(w < LIM), 32'h1);
    @(negedge clk);
    s0_read = 1'b0;
    #1;
    chk("s0_rvalid", 32'(s0_readDataValid), 32'h1);
    d = s0_readData;
  endtask

  task automatic s0_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       output int w);
    @(negedge clk);
    s0_address = a; s0_writeData = d; s0_byteEnable = be; s0_write = 1'b1; s0_read = 1'b0; w = 0;
    #1;
    while (s0_waitRequest !== 1'b0 && w < LIM) begin @(negedge clk); #1; w++; end
    chk("s0_wr_accept", 32'(w < LIM), 32'h1);
    @(negedge clk);
    s0_write = 1'b0;
    #1;
  endtask

  task automatic wait_init(output int n, output logic strobe);
    n = 0; strobe = 1'b0;
    while (s0_waitRequest === 1'b1 && n < 1000) begin
      n++;
      if (m0_read || m0_write) strobe = 1'b1;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] d, a, wd;
    logic [3:0]  be;
    logic        strobe;
    int          w, n;
    rest = 1'b0;
    s0_address = '0; s0_byteEnable = '0; s0_read = 1'b0; s0_write = 1'b0; s0_writeData = '0;
    s1_address = '0; s1_byteEnable = '0; s1_read = 1'b0; s1_write = 1'b0; s1_writeData = '0;

    // reset and invalidation sweep
    repeat (5) @(negedge clk);
    #1;
    chk("rst_s0_wait", 32'(s0_waitRequest), 32'h1);
    chk("rst_s0_rvalid", 32'(s0_readDataValid), 32'h0);
    chk("rst_m0_strobes", {29'h0, m0_read, m0_write, m0_beginBurstTransfer}, 32'h0);
    repeat (5) @(negedge clk);
    rest = 1'b1;
    #1;
    wait_init(n, strobe);
    chk("init_cycles", 32'(n), 32'd256);
    chk("init_no_m0", 32'(strobe), 32'h0);

    // cold read miss: 8-beat refill, then hit
    clr_log();
    s0_rd(32'h40, d, w);
    chk("cold_data", d, 32'h0);
    chk("cold_beats", 32'(lg_addr.size()), 32'd8);
    for (int i = 0; i < lg_addr.size(); i++) begin
      chk("cold_addr", lg_addr[i], 32'h40 + 32'(4 * i));
      chk("cold_ctl", {22'h0, lg_wr[i], lg_bg[i], lg_bc[i]}, {22'h0, 1'b0, 1'(i == 0), 8'd8});
    end
    clr_log();
    s0_rd(32'h40, d, w);
    chk("hit_wait", 32'(w), 32'h0);
    chk("hit_data", d, 32'h0);
    chk("hit_no_m0", 32'(lg_addr.size()), 32'h0);

    // byte-enabled write hit
    s0_wr(32'h40, 32'hA5A5A5A5, 4'b0101, w);
    chk("wr_hit_wait", 32'(w), 32'h0);
    s0_rd(32'h40, d, w);
    chk("wr_merge", d, 32'h00A500A5);
    chk("wr_no_m0", 32'(lg_addr.size()), 32'h0);

    // conflict miss on a dirty line: writeback then refill
    s0_rd(32'h2040, d, w);
    chk("conf_data", d, 32'h0);
    chk("conf_beats", 32'(lg_addr.size()), 32'd16);
    for (int i = 0; i < lg_addr.size(); i++) begin
      chk("conf_addr", lg_addr[i], (i < 8) ? 32'h40 + 32'(4 * i) : 32'h2040 + 32'(4 * (i - 8)));
      chk("conf_ctl", {23'h0, lg_wr[i], lg_bg[i]}, {23'h0, 1'(i < 8), 1'(i == 0 || i == 8)});
      if (i < 8) chk("wb_data", lg_data[i], (i == 0) ? 32'h00A500A5 : 32'h0);
    end
    clr_log();
    s0_rd(32'h40, d, w);
    chk("reload_data", d, 32'h00A500A5);
    chk("reload_beats", 32'(lg_addr.size()), 32'd8);
    chk("reload_first_rd", 32'(lg_wr[0]), 32'h0);

    // fill and writeback under random memory stalls
    for (int i = 0; i < 8; i++) mem[32'h4000 + 32'(4 * i)] = 32'h10000000 + 32'(i);
    rand_wait = 1'b1;
    s0_rd(32'h400C, d, w);
    chk("stall_fill", d, 32'h10000003);
    s0_rd(32'h401C, d, w);
    chk("stall_hit", d, 32'h10000007);
    s0_wr(32'h4000, 32'hDEADBEEF, 4'hF, w);
    clr_log();
    s0_rd(32'h6000, d, w);
    chk("stall_conf_data", d, 32'h0);
    chk("stall_conf_beats", 32'(lg_addr.size()), 32'd16);
    chk("stall_wb_first", lg_data[0], 32'hDEADBEEF);
    chk("stall_wb_mem0", mem_rd(32'h4000), 32'hDEADBEEF);
    chk("stall_wb_mem7", mem_rd(32'h401C), 32'h10000007);

    // random mix against a shadow of the CPU-visible memory
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 1) a = {$urandom_range(0, 32'h1FFFFFF)} & 32'hFFFFFFFC;
      else a = (32'($urandom_range(0, 3)) << 13) | (32'($urandom_range(0, 63)) << 2);
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom;
        be = 4'($urandom_range(0, 15));
        s0_wr(a, wd, be, w);
        shadow[a] = merge(sh_rd(a), wd, be);
      end else begin
        s0_rd(a, d, w);
        chk("rand_rd", d, sh_rd(a));
      end
    end

    // uncached port
    clr_log();
`ifdef CACHE_S1_BYPASS_EN
    @(negedge clk);
    s1_address = 32'h300; s1_writeData = 32'h12345678; s1_byteEnable = 4'hF; s1_write = 1'b1; w = 0;
    #1;
    while (s1_waitRequest !== 1'b0 && w < LIM) begin @(negedge clk); #1; w++; end
    @(negedge clk);
    s1_write = 1'b0;
    #1;
    chk("s1_wr_beats", 32'(lg_addr.size()), 32'd1);
    chk("s1_wr_ctl", {23'h0, lg_bg[0], lg_bc[0]}, {23'h0, 1'b0, 8'd1});
    chk("s1_wr_mem", mem_rd(32'h300), 32'h12345678);
    @(negedge clk);
    s1_read = 1'b1; w = 0;
    #1;
    while (s1_waitRequest !== 1'b0 && w < LIM) begin @(negedge clk); #1; w++; end
    @(negedge clk);
    s1_read = 1'b0;
    #1;
    w = 0;
    while (s1_readDataValid !== 1'b1 && w < LIM) begin @(negedge clk); #1; w++; end
    chk("s1_rd_valid", 32'(w < LIM), 32'h1);
    chk("s1_rd_data", s1_readData, 32'h12345678);
`else
    @(negedge clk);
    s1_address = 32'h300; s1_read = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("s1_off_wait", 32'(s1_waitRequest), 32'h1);
    chk("s1_off_rvalid", 32'(s1_readDataValid), 32'h0);
    chk("s1_off_rdata", s1_readData, 32'h0);
    chk("s1_off_no_m0", 32'(lg_addr.size()), 32'h0);
    s1_read = 1'b0;
`endif

    // reset during a burst stops m0 at once and restarts the sweep
    rand_wait = 1'b0;
    @(negedge clk);
    s0_address = 32'hF0000040; s0_read = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("burst_active", 32'(m0_read | m0_write), 32'h1);
    rest = 1'b0;
    #1;
    chk("abort_strobes", {30'h0, m0_read, m0_write}, 32'h0);
    chk("abort_wait", 32'(s0_waitRequest), 32'h1);
    s0_read = 1'b0;
    repeat (3) @(negedge clk);
    rest = 1'b1;
    #1;
    wait_init(n, strobe);
    chk("reinit_cycles", 32'(n), 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
